// File: rtl/dds_tuning_pkg.sv
// Shared types and default 125 MHz timing constants for the DDS push-button tuning controller.
package dds_tuning_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRE   = 2'd1,
        HOLD   = 2'd2,
        REPEAT = 2'd3
    } btn_state_t;

    typedef enum logic {
        COARSE = 1'b0,
        FINE   = 1'b1
    } adj_mode_t;

    // 10 ms debounce, 500 ms hold before repeat, 100 ms repeat period at 125 MHz
    localparam int DEF_DEBOUNCE_CYCLES = 1_250_000;
    localparam int DEF_REPEAT_DELAY    = 62_500_000;
    localparam int DEF_REPEAT_RATE     = 12_500_000;

endpackage

// File: rtl/dds_tuning_ctrl_btn.sv
// One push-button channel: 2-FF synchroniser, counting debouncer and hold-to-repeat FSM.
// step_o is a single-cycle pulse; level_o is the debounced button level.
module dds_btn_debounce
    import dds_tuning_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    input  logic force_idle_i,
    output logic level_o,
    output logic step_o
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    logic              sync1_q, sync2_q;
    logic              level_q, level_d, prev_q;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    btn_state_t        state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              step;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        db_cnt_d = '0;
        level_d  = level_q;
        if (sync2_q != level_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) level_d = sync2_q;
            else                                        db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (level_q && !prev_q) state_d = FIRE;
            end
            FIRE: begin
                step    = 1'b1;
                state_d = HOLD;
                tmr_d   = '0;
            end
            HOLD: begin
                if (tmr_q == TMR_W'(REPEAT_DELAY - 1)) begin
                    state_d = REPEAT;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            REPEAT: begin
                if (tmr_q == TMR_W'(REPEAT_RATE - 1)) begin
                    step  = 1'b1;
                    tmr_d = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Release or a two-button chord parks the FSM until a fresh rising edge
        if (!level_q || force_idle_i) begin
            state_d = IDLE;
            tmr_d   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            level_q  <= 1'b0;
            prev_q   <= 1'b0;
            db_cnt_q <= '0;
            state_q  <= IDLE;
            tmr_q    <= '0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            level_q  <= level_d;
            prev_q   <= level_q;
            db_cnt_q <= db_cnt_d;
            state_q  <= state_d;
            tmr_q    <= tmr_d;
        end
    end

    assign level_o = level_q;
    assign step_o  = step && !force_idle_i;

endmodule

// File: rtl/dds_tuning_ctrl.sv
// Push-button DDS tuning controller: coarse/fine indices into a coarse ROM, registered phase increment.
// Build option DDS_TUNING_WRAP_EN: indices wrap instead of saturating and o_at_limit is tied low.
module dds_tuning_ctrl
    import dds_tuning_pkg::*;
#(
    parameter int INC_WIDTH       = 32,
    parameter int COARSE_DEPTH    = 16,
    parameter int FINE_STEPS      = 8,
    parameter int FINE_SHIFT      = 3,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
    localparam int CW = $clog2(COARSE_DEPTH),
    localparam int FW = $clog2(FINE_STEPS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_enable,
    input  logic                 i_aumentar,
    input  logic                 i_disminuir,
    input  logic                 i_tipo_ajuste,
    input  logic [INC_WIDTH-1:0] i_rom_incremento_grueso [COARSE_DEPTH],
    output logic [CW-1:0]        o_leds_grueso,
    output logic [FW-1:0]        o_leds_fino,
    output logic [INC_WIDTH-1:0] o_incremento,
    output logic                 o_inc_valid,
    output logic                 o_at_limit
);

    localparam logic [CW-1:0] C_MAX = CW'(COARSE_DEPTH - 1);
    localparam logic [FW-1:0] F_MAX = FW'(FINE_STEPS - 1);

    logic                 mode_s1_q, mode_s2_q;
    adj_mode_t            mode;
    logic                 lvl_up, lvl_dn, step_up, step_dn, both_held;
    logic [CW-1:0]        coarse_q, coarse_d;
    logic [FW-1:0]        fine_q, fine_d;
    logic                 chg_q, chg_d;
    logic                 init_q, valid_q;
    logic                 limit_q, limit_d;
    logic [INC_WIDTH-1:0] inc_q, inc_d, base, fine_step;

    assign both_held = lvl_up & lvl_dn;
    assign mode      = adj_mode_t'(mode_s2_q);

    dds_btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_RATE     (REPEAT_RATE)
    ) u_btn_up (
        .clk_i        (i_clk),
        .rst_i        (i_rst),
        .btn_i        (i_aumentar),
        .force_idle_i (both_held),
        .level_o      (lvl_up),
        .step_o       (step_up)
    );

    dds_btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_RATE     (REPEAT_RATE)
    ) u_btn_dn (
        .clk_i        (i_clk),
        .rst_i        (i_rst),
        .btn_i        (i_disminuir),
        .force_idle_i (both_held),
        .level_o      (lvl_dn),
        .step_o       (step_dn)
    );

    always_comb begin
        coarse_d = coarse_q;
        fine_d   = fine_q;
        chg_d    = 1'b0;
        if (i_enable && (step_up != step_dn)) begin
            if (mode == COARSE) begin
                if (step_up && coarse_q != C_MAX)    coarse_d = coarse_q + 1'b1;
                else if (step_dn && coarse_q != '0)  coarse_d = coarse_q - 1'b1;
`ifdef DDS_TUNING_WRAP_EN
                else if (step_up)                    coarse_d = '0;
                else                                 coarse_d = C_MAX;
`endif
                chg_d = (coarse_d != coarse_q);
                if (chg_d) fine_d = '0;
            end else begin
                if (step_up && fine_q != F_MAX)      fine_d = fine_q + 1'b1;
                else if (step_dn && fine_q != '0)    fine_d = fine_q - 1'b1;
`ifdef DDS_TUNING_WRAP_EN
                else if (step_up)                    fine_d = '0;
                else                                 fine_d = F_MAX;
`endif
                chg_d = (fine_d != fine_q);
            end
        end
    end

    always_comb begin
`ifdef DDS_TUNING_WRAP_EN
        limit_d = 1'b0;
`else
        if (mode == COARSE) limit_d = (coarse_q == '0) || (coarse_q == C_MAX);
        else                limit_d = (fine_q == '0) || (fine_q == F_MAX);
`endif
    end

    // Recomputed every cycle so a live ROM rewrite reaches the output without an index step
    always_comb begin
        base      = i_rom_incremento_grueso[coarse_q];
        fine_step = base >> FINE_SHIFT;
        inc_d     = base + INC_WIDTH'(fine_q) * fine_step;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mode_s1_q <= 1'b0;
            mode_s2_q <= 1'b0;
            coarse_q  <= '0;
            fine_q    <= '0;
            chg_q     <= 1'b0;
            init_q    <= 1'b1;
            valid_q   <= 1'b0;
            limit_q   <= 1'b0;
            inc_q     <= '0;
        end else begin
            mode_s1_q <= i_tipo_ajuste;
            mode_s2_q <= mode_s1_q;
            coarse_q  <= coarse_d;
            fine_q    <= fine_d;
            chg_q     <= chg_d;
            init_q    <= 1'b0;
            valid_q   <= chg_q | init_q;
            limit_q   <= limit_d;
            inc_q     <= inc_d;
        end
    end

    assign o_leds_grueso = coarse_q;
    assign o_leds_fino   = fine_q;
    assign o_incremento  = inc_q;
    assign o_inc_valid   = valid_q;
    assign o_at_limit    = limit_q;

endmodule

// File: tb/tb_dds_tuning_ctrl.sv
// Directed bench for dds_tuning_ctrl with short debounce/repeat timing and the 16-entry coarse table.
module tb_dds_tuning_ctrl;
    import dds_tuning_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_enable = 1'b1;
    logic        i_aumentar = 1'b0;
    logic        i_disminuir = 1'b0;
    logic        i_tipo_ajuste = 1'b0;
    logic [31:0] rom [16];
    logic [3:0]  o_leds_grueso;
    logic [2:0]  o_leds_fino;
    logic [31:0] o_incremento;
    logic        o_inc_valid;
    logic        o_at_limit;

    int n_checks = 0;
    int n_fail   = 0;
    int vcnt     = 0;
    int base_cnt = 0;

`ifdef DDS_TUNING_WRAP_EN
    localparam logic EXP_LIM = 1'b0;
`else
    localparam logic EXP_LIM = 1'b1;
`endif

    dds_tuning_ctrl #(
        .INC_WIDTH       (32),
        .COARSE_DEPTH    (16),
        .FINE_STEPS      (8),
        .FINE_SHIFT      (3),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_RATE     (5)
    ) dut (
        .i_clk                   (i_clk),
        .i_rst                   (i_rst),
        .i_enable                (i_enable),
        .i_aumentar              (i_aumentar),
        .i_disminuir             (i_disminuir),
        .i_tipo_ajuste           (i_tipo_ajuste),
        .i_rom_incremento_grueso (rom),
        .o_leds_grueso           (o_leds_grueso),
        .o_leds_fino             (o_leds_fino),
        .o_incremento            (o_incremento),
        .o_inc_valid             (o_inc_valid),
        .o_at_limit              (o_at_limit)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) if (o_inc_valid) vcnt <= vcnt + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic press(input bit up, input int hold);
        if (up) i_aumentar = 1'b1;
        else    i_disminuir = 1'b1;
        repeat (hold) tick();
        i_aumentar  = 1'b0;
        i_disminuir = 1'b0;
        repeat (15) tick();
    endtask

    task automatic set_mode(input logic m);
        i_tipo_ajuste = m;
        repeat (4) tick();
    endtask

    function automatic logic [31:0] exp_inc(input int c, input int f);
        return rom[c] + 32'(f) * (rom[c] >> 3);
    endfunction

    initial begin
        rom = '{32'h00008638, 32'h0000C898, 32'h00010C6F, 32'h000192A6,
                32'h000218DE, 32'h0003254D, 32'h00043179, 32'h00064A3D,
                32'h000862F2, 32'h000C946E, 32'h0010C6F8, 32'h00192A72,
                32'h00218DEF, 32'h003254E7, 32'h00431BDE, 32'h020A1F1A};

        // 1: reset state and the single post-reset load
        repeat (3) tick();
        check("rst_inc", o_incremento, 0);
        check("rst_valid", o_inc_valid, 0);
        check("rst_lim", o_at_limit, 0);
        i_rst = 1'b0;
        tick();
        check("init_valid", o_inc_valid, 1);
        check("init_inc", o_incremento, 32'h00008638);
        check("init_grueso", o_leds_grueso, 0);
        check("init_fino", o_leds_fino, 0);
        tick();
        check("init_once", o_inc_valid, 0);
        check("init_lim", o_at_limit, EXP_LIM);
        repeat (5) tick();

        // 2: coarse up, exact latency, then a short glitch
        base_cnt = vcnt;
        i_aumentar = 1'b1;
        repeat (6) tick();
        i_aumentar = 1'b0;
        repeat (2) tick();
        check("lat_early", o_inc_valid, 0);
        tick();
        check("lat_valid", o_inc_valid, 1);
        check("up_inc", o_incremento, 32'h0000C898);
        check("up_grueso", o_leds_grueso, 1);
        repeat (15) tick();
        check("up_pulses", vcnt - base_cnt, 1);
        base_cnt = vcnt;
        press(1, 3);
        check("glitch_grueso", o_leds_grueso, 1);
        check("glitch_pulses", vcnt - base_cnt, 0);

        // 3: fine steps at coarse 0
        press(0, 6);
        check("dn_grueso", o_leds_grueso, 0);
        set_mode(1'b1);
        base_cnt = vcnt;
        press(1, 6);
        press(1, 6);
        check("fine_fino", o_leds_fino, 2);
        check("fine_inc", o_incremento, 32'h0000A7C6);
        check("fine_pulses", vcnt - base_cnt, 2);
        check("fine_lim", o_at_limit, 0);
        press(1, 6);
        check("fine3_inc", o_incremento, 32'h0000B88D);

        // 5: two-button chord issues nothing; coarse change clears fine
        set_mode(1'b0);
        base_cnt = vcnt;
        i_aumentar = 1'b1;
        i_disminuir = 1'b1;
        repeat (10) tick();
        i_disminuir = 1'b0;
        repeat (40) tick();
        i_aumentar = 1'b0;
        repeat (15) tick();
        check("chord_pulses", vcnt - base_cnt, 0);
        check("chord_grueso", o_leds_grueso, 0);
        check("chord_fino", o_leds_fino, 3);
        press(1, 6);
        check("clr_grueso", o_leds_grueso, 1);
        check("clr_fino", o_leds_fino, 0);
        check("clr_inc", o_incremento, 32'h0000C898);

        // 4: limits
`ifndef DDS_TUNING_WRAP_EN
        base_cnt = vcnt;
        press(1, 200);
        check("sat_pulses", vcnt - base_cnt, 14);
        check("sat_grueso", o_leds_grueso, 15);
        check("sat_inc", o_incremento, 32'h020A1F1A);
        check("sat_lim", o_at_limit, 1);
        base_cnt = vcnt;
        press(1, 6);
        check("sat_hold", vcnt - base_cnt, 0);
        set_mode(1'b1);
        check("fsat_lim", o_at_limit, 1);
        base_cnt = vcnt;
        press(0, 6);
        check("fsat_fino", o_leds_fino, 0);
        check("fsat_pulses", vcnt - base_cnt, 0);
        set_mode(1'b0);
`else
        press(0, 6);
        press(0, 6);
        check("wrap_grueso", o_leds_grueso, 15);
        check("wrap_inc", o_incremento, 32'h020A1F1A);
        check("wrap_lim", o_at_limit, 0);
        press(1, 6);
        check("wrap_up", o_leds_grueso, 0);
        press(0, 6);
        set_mode(1'b1);
        press(0, 6);
        check("fwrap_fino", o_leds_fino, 7);
        check("fwrap_inc", o_incremento, exp_inc(15, 7));
        set_mode(1'b0);
`endif

        // 6: enable gating, repeat timing, reset mid-repeat, live ROM rewrite
        i_enable = 1'b0;
        base_cnt = vcnt;
        press(0, 6);
        check("en_grueso", o_leds_grueso, 15);
        check("en_pulses", vcnt - base_cnt, 0);
        i_enable = 1'b1;
        base_cnt = vcnt;
        i_disminuir = 1'b1;
        repeat (60) tick();
        check("rep_grueso", o_leds_grueso, 8);
        check("rep_inc", o_incremento, exp_inc(8, 0));
        check("rep_pulses", vcnt - base_cnt, 7);
        i_rst = 1'b1;
        i_disminuir = 1'b0;
        tick();
        check("mid_inc", o_incremento, 0);
        check("mid_valid", o_inc_valid, 0);
        check("mid_grueso", o_leds_grueso, 0);
        check("mid_fino", o_leds_fino, 0);
        check("mid_lim", o_at_limit, 0);
        check("mid_st_up", dut.u_btn_up.state_q, IDLE);
        check("mid_st_dn", dut.u_btn_dn.state_q, IDLE);
        i_rst = 1'b0;
        tick();
        check("rel_valid", o_inc_valid, 1);
        check("rel_inc", o_incremento, 32'h00008638);
        tick();
        base_cnt = vcnt;
        rom[0] = 32'h00010000;
        repeat (2) tick();
        check("rom_inc", o_incremento, 32'h00010000);
        check("rom_pulses", vcnt - base_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
